video_stream_switch: RTL and testbench

Parametrised N-input video stream selector placed between the processing branches (LUT, binarisation, YCbCr, centroid overlays, filters, Sobel, HSV, erosion, bypass) and the HDMI output encoder. It replaces the fixed 13-way selector and adds three behaviours: channel-count and pixel-width generality, tear-free frame-synchronous switching with a blanked settle phase, and a watchdog against dead sources. All outputs are registered.

---
 rtl/video_switch_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 34 +++
 rtl/video_stream_switch.sv | 179 +++++++++++++++++
 tb/tb_video_stream_switch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_switch_pkg.sv
// Shared types and constants for the video stream switch.
// FSM state encoding, watchdog width and the blanking pixel value.
package video_switch_pkg;

    typedef enum logic [1:0] {
        LOCKED,
        PENDING,
        SETTLE
    } sw_state_e;

    localparam int WD_W      = 23;
    localparam int BLANK_PIX = 0;

endpackage

// File: rtl/sync_edge_detect.sv
// Per-channel vertical sync edge detector.
// Ports: clk, rst_n, v_sync[N_CH] in; frame_start[N_CH] (entering the
// active level), vsync_end[N_CH] (leaving the active level) out.
module sync_edge_detect #(
    parameter int N_CH   = 13,
    parameter bit VS_POL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] v_sync,
    output logic [N_CH-1:0] frame_start,
    output logic [N_CH-1:0] vsync_end
);

    logic [N_CH-1:0] vs_prev;
    logic [N_CH-1:0] vs_act;
    logic [N_CH-1:0] prev_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= {N_CH{~VS_POL}};
        end else begin
            vs_prev <= v_sync;
        end
    end

    // Normalise to active-high so edge logic is polarity independent.
    assign vs_act   = VS_POL ? v_sync  : ~v_sync;
    assign prev_act = VS_POL ? vs_prev : ~vs_prev;

    assign frame_start = vs_act & ~prev_act;
    assign vsync_end   = ~vs_act & prev_act;

endmodule

// File: rtl/video_stream_switch.sv
// N-input video stream selector with frame-synchronous, tear-free switching,
// a blanked settle phase after each switch and a dead-source watchdog.
// Ports: clk, rst_n, per-channel de_in/v_sync_in/h_sync_in/pixel_in, sel in;
// registered de_out/v_sync_out/h_sync_out/pixel_out, active_ch,
// switch_pending, sel_invalid, switch_done out.
module video_stream_switch
    import video_switch_pkg::*;
#(
    parameter int N_CH        = 13,
    parameter int PIX_W       = 24,
    parameter int SEL_W       = 4,
    parameter int DEFAULT_CH  = 0,
    parameter bit FRAME_SYNC  = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int TIMEOUT_CYC = 4194303
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       de_in,
    input  logic [N_CH-1:0]       v_sync_in,
    input  logic [N_CH-1:0]       h_sync_in,
    input  logic [N_CH*PIX_W-1:0] pixel_in,
    input  logic [SEL_W-1:0]      sel,
    output logic                  de_out,
    output logic                  v_sync_out,
    output logic                  h_sync_out,
    output logic [PIX_W-1:0]      pixel_out,
    output logic [SEL_W-1:0]      active_ch,
    output logic                  switch_pending,
    output logic                  sel_invalid,
    output logic                  switch_done
);

    localparam int NPAD = 2 ** SEL_W;

    localparam logic [SEL_W:0]   N_LIM  = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] DEF_CH = SEL_W'(DEFAULT_CH);
    localparam logic [WD_W-1:0]  WD_LIM = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [PIX_W-1:0] BLANK  = PIX_W'(BLANK_PIX);

    sw_state_e        state, state_n;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] act_n;
    logic [SEL_W-1:0] pend_ch, pend_n;
    logic [SEL_W-1:0] target;
    logic [WD_W-1:0]  wd, wd_n, wd_inc;
    logic             done_n;
    logic             sel_ok;
    logic             wd_hit;
    logic             blank;

    logic [N_CH-1:0]  fs, ve;

    // Channel vectors padded to the full select range so any active_ch
    // value indexes in range; padding channels read as idle.
    logic [NPAD-1:0]  de_pad, vs_pad, hs_pad, fs_pad, ve_pad;
    logic [PIX_W-1:0] pix_arr [NPAD];

    sync_edge_detect #(
        .N_CH   (N_CH),
        .VS_POL (VS_POL)
    ) u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .v_sync      (v_sync_in),
        .frame_start (fs),
        .vsync_end   (ve)
    );

    assign de_pad = NPAD'(de_in);
    assign vs_pad = NPAD'(v_sync_in);
    assign hs_pad = NPAD'(h_sync_in);
    assign fs_pad = NPAD'(fs);
    assign ve_pad = NPAD'(ve);

    for (genvar g = 0; g < NPAD; g++) begin : g_pix
        if (g < N_CH) begin : g_on
            assign pix_arr[g] = pixel_in[g*PIX_W +: PIX_W];
        end else begin : g_off
            assign pix_arr[g] = '0;
        end
    end

    assign sel_ok = ({1'b0, sel_q} < N_LIM);
    assign wd_hit = (wd == WD_LIM);
    assign blank  = (state == SETTLE);

    // Saturating increment: a stuck counter must not wrap back into range.
    assign wd_inc = (wd == '1) ? wd : wd + WD_W'(1);

    // An invalid request never retargets; keep the last valid one.
    assign target = sel_ok ? sel_q : pend_ch;

    always_comb begin
        state_n = state;
        act_n   = active_ch;
        pend_n  = pend_ch;
        wd_n    = wd;
        done_n  = 1'b0;
        unique case (state)
            LOCKED: begin
                wd_n = '0;
                if (sel_ok && (sel_q != active_ch)) begin
                    if (FRAME_SYNC) begin
                        state_n = PENDING;
                        pend_n  = sel_q;
                    end else begin
                        act_n  = sel_q;
                        done_n = 1'b1;
                    end
                end
            end
            PENDING: begin
                wd_n   = wd_inc;
                pend_n = target;
                // Cancel takes priority over a coincident frame start.
                if (sel_q == active_ch) begin
                    state_n = LOCKED;
                    wd_n    = '0;
                end else if (fs_pad[active_ch] || wd_hit) begin
                    act_n   = target;
                    done_n  = 1'b1;
                    state_n = SETTLE;
                    wd_n    = '0;
                end
            end
            SETTLE: begin
                wd_n = wd_inc;
                if (ve_pad[active_ch] || wd_hit) begin
                    state_n = LOCKED;
                    wd_n    = '0;
                end
            end
            default: begin
                state_n = LOCKED;
                wd_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOCKED;
            sel_q          <= DEF_CH;
            active_ch      <= DEF_CH;
            pend_ch        <= DEF_CH;
            wd             <= '0;
            switch_pending <= 1'b0;
            sel_invalid    <= 1'b0;
            switch_done    <= 1'b0;
        end else begin
            state          <= state_n;
            sel_q          <= sel;
            active_ch      <= act_n;
            pend_ch        <= pend_n;
            wd             <= wd_n;
            switch_pending <= (state_n == PENDING);
            sel_invalid    <= ~sel_ok;
            switch_done    <= done_n;
        end
    end

    // Output stage uses the current active_ch, so a commit shows up one
    // cycle later with the new channel's syncs and blanked data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out     <= 1'b0;
            v_sync_out <= 1'b0;
            h_sync_out <= 1'b0;
            pixel_out  <= '0;
        end else begin
            de_out     <= blank ? 1'b0 : de_pad[active_ch];
            v_sync_out <= vs_pad[active_ch];
            h_sync_out <= hs_pad[active_ch];
            pixel_out  <= blank ? BLANK : pix_arr[active_ch];
        end
    end

endmodule

// File: tb/tb_video_stream_switch.sv
// Scoreboard bench for video_stream_switch: one frame-synchronous instance
// (TIMEOUT_CYC=100) and one immediate-switch instance share the streams.
module tb_video_stream_switch;

    localparam int N  = 13;
    localparam int PW = 24;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    de_in = '0, vs_in = '0, hs_in = '0;
    logic [N*PW-1:0] pix_in = '0;
    logic [SW-1:0]   sel1 = '0, sel0 = '0;
    logic [N-1:0]    vsr = '0;

    logic            de1, vso1, hso1, pend1, inv1, done1;
    logic [PW-1:0]   pix1;
    logic [SW-1:0]   act1;
    logic            de0, vso0, hso0, pend0, inv0, done0;
    logic [PW-1:0]   pix0;
    logic [SW-1:0]   act0;

    video_stream_switch #(
        .N_CH(N), .PIX_W(PW), .SEL_W(SW), .DEFAULT_CH(0),
        .FRAME_SYNC(1'b1), .VS_POL(1'b1), .TIMEOUT_CYC(100)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .v_sync_in(vs_in),
        .h_sync_in(hs_in), .pixel_in(pix_in), .sel(sel1),
        .de_out(de1), .v_sync_out(vso1), .h_sync_out(hso1),
        .pixel_out(pix1), .active_ch(act1), .switch_pending(pend1),
        .sel_invalid(inv1), .switch_done(done1)
    );

    video_stream_switch #(
        .N_CH(N), .PIX_W(PW), .SEL_W(SW), .DEFAULT_CH(0),
        .FRAME_SYNC(1'b0), .VS_POL(1'b1), .TIMEOUT_CYC(100)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .v_sync_in(vs_in),
        .h_sync_in(hs_in), .pixel_in(pix_in), .sel(sel0),
        .de_out(de0), .v_sync_out(vso0), .h_sync_out(hso0),
        .pixel_out(pix0), .active_ch(act0), .switch_pending(pend0),
        .sel_invalid(inv0), .switch_done(done0)
    );

    typedef struct packed {
        logic          de;
        logic          vs;
        logic          hs;
        logic [PW-1:0] pix;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   d1[$];
    int   d0[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input bit b);
        exp_t e;
        e.de  = de_in[c] & ~b;
        e.vs  = vs_in[c];
        e.hs  = hs_in[c];
        e.pix = b ? '0 : pix_in[c*PW +: PW];
        return e;
    endfunction

    // Drive one input cycle; c1/c0 are the channels each instance is
    // expected to forward for it, b1 whether dut1 blanks it.
    task automatic step(input int c1, input bit b1, input int c0);
        for (int k = 0; k < N; k++) begin
            de_in[k] = ((cyc + k) % 7) != 3;
            hs_in[k] = ((cyc + k) % 5) == 0;
            pix_in[k*PW +: PW] = {8'(k), 16'(cyc)};
        end
        vs_in = vsr;
        q1.push_back(mk(c1, b1));
        q0.push_back(mk(c0, 1'b0));
        mon_en = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int c1, input bit b1,
                       input int c0);
        for (int i = 0; i < n; i++) step(c1, b1, c0);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL stream1 no expectation queued");
            end else begin
                chk("stream1", {5'd0, de1, vso1, hso1, pix1}, {5'd0, q1.pop_front()});
            end
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL stream0 no expectation queued");
            end else begin
                chk("stream0", {5'd0, de0, vso0, hso0, pix0}, {5'd0, q0.pop_front()});
            end
            if (done1) begin
                if (d1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done1 unexpected pulse ch %0d", act1);
                end else begin
                    chk("done1_ch", 32'(act1), 32'(d1.pop_front()));
                end
            end
            if (done0) begin
                if (d0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done0 unexpected pulse ch %0d", act0);
                end else begin
                    chk("done0_ch", 32'(act0), 32'(d0.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out1", {5'd0, de1, vso1, hso1, pix1}, 32'd0);
        chk("rst_st1", {25'd0, act1, pend1, inv1, done1}, 32'd0);
        chk("rst_out0", {5'd0, de0, vso0, hso0, pix0}, 32'd0);
        chk("rst_st0", {25'd0, act0, pend0, inv0, done0}, 32'd0);
        rst_n = 1'b1;

        run(4, 0, 0, 0);

        // Immediate switching: 0->2 then 2->7.
        d0.push_back(2);
        sel0 = 4'd2;
        run(2, 0, 0, 0);
        run(3, 0, 0, 2);
        d0.push_back(7);
        sel0 = 4'd7;
        step(0, 0, 2);
        chk("fs0_nodone_early", {31'd0, done0}, 32'd0);
        step(0, 0, 2);
        chk("fs0_done", {27'd0, done0, act0}, {27'd1, 4'd7});
        run(3, 0, 0, 7);

        // Frame-synchronous 0->5 mid-frame.
        d1.push_back(5);
        sel1 = 4'd5;
        run(2, 0, 0, 7);
        chk("b_pend", {27'd0, pend1, act1}, {27'd1, 4'd0});
        run(4, 0, 0, 7);
        chk("b_hold", {27'd0, pend1, act1}, {27'd1, 4'd0});
        vsr[0] = 1'b1;
        step(0, 0, 7);
        chk("b_commit", {27'd0, pend1, act1}, {27'd0, 4'd5});
        run(2, 5, 1, 7);
        vsr[5] = 1'b1;
        run(3, 5, 1, 7);
        vsr[5] = 1'b0;
        step(5, 1, 7);
        vsr[0] = 1'b0;
        run(4, 5, 0, 7);

        // Request and withdraw; frame start coincides with cancel.
        sel1 = 4'd0;
        run(2, 5, 0, 7);
        chk("c_pend", {31'd0, pend1}, 32'd1);
        sel1 = 4'd5;
        step(5, 0, 7);
        vsr[5] = 1'b1;
        run(2, 5, 0, 7);
        chk("c_cancel", {27'd0, pend1, act1}, {27'd0, 4'd5});
        run(3, 5, 0, 7);
        vsr[5] = 1'b0;
        run(2, 5, 0, 7);

        // Out-of-range select.
        sel1 = 4'd14;
        run(3, 5, 0, 7);
        chk("d_invalid", {26'd0, inv1, pend1, act1}, {26'd2, 4'd5});
        sel1 = 4'd5;
        run(3, 5, 0, 7);
        chk("d_valid", {31'd0, inv1}, 32'd0);

        // Dead active source and silent target: both watchdog paths.
        d1.push_back(3);
        sel1 = 4'd3;
        run(2, 5, 0, 7);
        chk("e_pend", {31'd0, pend1}, 32'd1);
        run(99, 5, 0, 7);
        chk("e_not_yet", {28'd0, act1}, 32'd5);
        step(5, 0, 7);
        chk("e_forced", {27'd0, done1, act1}, {27'd1, 4'd3});
        run(100, 3, 1, 7);
        run(3, 3, 0, 7);

        // Reset while a switch is pending.
        sel1 = 4'd6;
        run(3, 3, 0, 7);
        chk("r_pend_before", {31'd0, pend1}, 32'd1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("r_async", {27'd0, pend1, act1}, 32'd0);
        chk("r_out", {5'd0, de1, vso1, hso1, pix1}, 32'd0);
        q1.delete();
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0.push_back(7);
        run(2, 0, 0, 0);
        chk("r_reeval", {27'd0, pend1, act1}, {27'd1, 4'd0});
        run(3, 0, 0, 7);

        chk("drain_q1", 32'(q1.size()), 32'd0);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_d1", 32'(d1.size()), 32'd0);
        chk("drain_d0", 32'(d0.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
